// File: rtl/dpe_accumulator.sv
// dpe_accumulator: running accumulator behind the CSA_N reduction tree.
// Sums unsigned partial sums into a wide accumulator, closes a group on
// in_last or after MAX_TERMS beats, and queues each finished group in a
// 2-entry output FIFO.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. A source seeing its
// ready low must hold valid and payload unchanged until the transfer.
`timescale 1ns/1ps
module dpe_accumulator #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = WIDTH + 8,
  parameter int MAX_TERMS = 16,
  localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_overflow,
  output logic                 out_trunc,
  output logic                 o_dbg_state
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  // Accumulator state
  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;

  // Output FIFO storage
  logic [ACC_WIDTH-1:0] r_q_data  [2];
  logic [CNT_W-1:0]     r_q_count [2];
  logic                 r_q_ovf   [2];
  logic                 r_q_trunc [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_fcnt;

  logic                 w_in_fire;
  logic                 w_pop;
  logic [ACC_WIDTH:0]   w_sum;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_close;
  logic                 w_carry;

  // Room exists when the FIFO is not full, or when the head leaves this edge.
  assign in_ready  = rst_n && (!r_fcnt[1] || out_ready);
  assign w_in_fire = in_valid && in_ready;
  assign w_pop     = (r_fcnt != 2'd0) && out_ready;

  // One extra bit on the adder captures the carry-out of ACC_WIDTH.
  assign w_sum     = {1'b0, r_acc} + (ACC_WIDTH + 1)'(in_sum);
  assign w_carry   = w_sum[ACC_WIDTH];
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_close   = w_in_fire && (in_last || (w_cnt_nxt == CNT_W'(MAX_TERMS)));

  // Group FSM: a closing beat hands its totals to the FIFO and returns to EMPTY
  // on the same edge, so the next beat can start a new group immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_in_fire) begin
      if (w_close) begin
        r_state <= S_EMPTY;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_state <= S_ACCUM;
        r_acc   <= w_sum[ACC_WIDTH-1:0];
        r_cnt   <= w_cnt_nxt;
        r_ovf   <= r_ovf | w_carry;
      end
    end
  end

  // Two-entry FIFO; push and pop may coincide, including when full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_q_data[i]  <= '0;
        r_q_count[i] <= '0;
        r_q_ovf[i]   <= 1'b0;
        r_q_trunc[i] <= 1'b0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_fcnt   <= 2'd0;
    end else begin
      if (w_close) begin
        r_q_data[r_wr_ptr]  <= w_sum[ACC_WIDTH-1:0];
        r_q_count[r_wr_ptr] <= w_cnt_nxt;
        r_q_ovf[r_wr_ptr]   <= r_ovf | w_carry;
        r_q_trunc[r_wr_ptr] <= !in_last;
        r_wr_ptr            <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_close, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 2'd1;
        2'b01:   r_fcnt <= r_fcnt - 2'd1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign out_valid    = (r_fcnt != 2'd0);
  assign out_data     = r_q_data[r_rd_ptr];
  assign out_count    = r_q_count[r_rd_ptr];
  assign out_overflow = r_q_ovf[r_rd_ptr];
  assign out_trunc    = r_q_trunc[r_rd_ptr];
  assign o_dbg_state  = r_state;

endmodule

// File: doc/dpe_accumulator.md
# dpe_accumulator

Sequential accumulation stage placed directly downstream of the combinational `CSA_N` carry-save reduction tree in the DPE datapath. Each cycle it can take one reduced partial sum `s` from `CSA_N` and add it into a wide running accumulator. It closes a dot-product group on an explicit `last` marker or when a term limit is reached. Completed results go into a 2-entry output FIFO with valid/ready handshake, so downstream backpressure never corrupts a group.

## Interface
- `WIDTH`, default = DPE_params `WIDTH`, bit width of `in_sum` (the `CSA_N` output width)
- `ACC_WIDTH`, default `WIDTH+8`, accumulator and result width; must be ≥ `WIDTH`
- `MAX_TERMS`, default 16, maximum beats per group (≥ 1)
- `CNT_W`, derived as `$clog2(MAX_TERMS+1)`, term-count width
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  `in_sum`/`in_last` valid
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `in_sum`  in  `WIDTH`  unsigned partial sum from `CSA_N`
- `in_last`  in  1  final beat of current group
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  downstream accepts head
- `out_data`  out  `ACC_WIDTH`  accumulated group sum
- `out_count`  out  `CNT_W`  number of beats in the group
- `out_overflow`  out  1  sticky: accumulator carried out of `ACC_WIDTH` during the group
- `out_trunc`  out  1  group was closed by `MAX_TERMS`, not by `in_last`

## Operation
- Arithmetic is unsigned. `in_sum` is zero-extended to `ACC_WIDTH`. Accumulation wraps modulo 2^`ACC_WIDTH`. Any carry-out sets the sticky overflow bit for the group.
- State machine:
  - EMPTY: acc = 0, count = 0, ovf = 0.
  - ACCUM: count ≥ 1.
  - EMPTY → ACCUM on an accepted non-closing beat.
  - ACCUM → ACCUM on a non-closing beat.
  - Any state → EMPTY on a closing beat.
- A closing beat is an accepted beat with `in_last` = 1, or the beat that makes count = `MAX_TERMS`.
- On a closing beat, the FIFO is written with:
  - `out_data` = acc + `in_sum`, including that beat;
  - `out_count` = count + 1;
  - `out_overflow` = ovf OR carry;
  - `out_trunc` = !`in_last`.
- In the same edge, acc, count and ovf return to EMPTY values. There is no idle bubble.
- Single-beat groups are legal back-to-back.
- Output FIFO: 2 entries, strict in-order delivery.
  - `out_*` always show the head entry.
  - Head is popped on `out_valid && out_ready`.
  - A simultaneous push and pop is legal when the FIFO is full.
- `in_ready` = `rst_n` AND (FIFO count < 2 OR `out_ready`). When `in_ready` is high, any beat is accepted, including non-closing beats.
- A beat offered while `in_ready` = 0 is not consumed. The source must hold it (standard valid/ready).

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - FIFO emptied, accumulator state to EMPTY;
  - `out_valid` = 0, `out_data` = 0, `out_count` = 0, `out_overflow` = 0, `out_trunc` = 0;
  - `in_ready` = 0 while `rst_n` is low.
- Reset mid-group discards the partial group and all buffered results. The first beat after release starts a new group.
- Latency: closing beat accepted at edge N → `out_valid` = 1 after edge N when the FIFO was empty.
- Throughput: 1 beat per cycle sustained with `out_ready` held at 1.
- `out_valid` and the `out_*` fields depend only on registers. `in_ready` is the only combinational output; its path is `out_ready` → `in_ready`.
- `out_*` must hold stable while `out_valid && !out_ready`.

## Test plan
Build: `WIDTH` = 16, `ACC_WIDTH` = 24, `MAX_TERMS` = 16 unless noted.
1. Basic group. Beats 100, 200, 300 with last on the third, `out_ready` = 1. Required: one result `out_data` = 600, `out_count` = 3, overflow = 0, trunc = 0. `out_valid` rises the cycle after the third beat.
2. Back-to-back single-beat groups. Values 5, 7, 9, each with last, over consecutive cycles, `out_ready` = 1. Required: results 5, 7, 9 in order, each with count = 1; `in_ready` stays 1 throughout.
3. Backpressure. `out_ready` = 0; offer single-beat groups 1, 2, 3.
   - 1 and 2 are buffered; `in_ready` drops; 3 is held.
   - Raise `out_ready`: outputs 1, 2, 3 in order.
   - `out_data` stays stable at 1 while stalled.
4. Overflow (`ACC_WIDTH` = 17 build). Three beats of 0xFFFF with last. Required: `out_data` = 0x0FFFD, `out_overflow` = 1. The next group (beat 1, last) gives `out_overflow` = 0.
5. Truncation. Seventeen beats of value 1, none with last, then one beat of 1 with last.
   - First result: `out_data` = 16, count = 16, trunc = 1.
   - Second result: `out_data` = 2, count = 2, trunc = 0.
6. Reset mid-operation.
   - Setup: accept beats 10, 20 with no last; a prior result is held with `out_ready` = 0. Pulse `rst_n` low for one cycle.
   - During reset: `out_valid` = 0.
   - After release, group (4, last) → only output is 4, count = 1.
